// File: rtl/trace_scheduler.sv
// Trace scheduler: buffers host trace addresses and issues them one at a time to the cache model.
// Optional watchdog in WAIT enabled by defining TRACE_SCHED_TIMEOUT_EN.
module trace_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 20,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    output logic                          wr_ready,
    input  logic                          cache_done,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          trace_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              issued_count,
    output logic                          timeout_err
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [LVL_W-1:0]   wr_ptr_r, rd_ptr_r, level_r, level_s;
    logic               wr_ready_r, trace_ready_r, busy_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [CNT_W-1:0]   issued_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               push_s, pop_s, done_hit_s, timeout_hit_s;

    assign push_s = wr_valid && wr_ready_r;
    assign pop_s  = (state_r == ST_ISSUE);

`ifdef TRACE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_err_r;

    // Watchdog: cleared while issuing, counts every WAIT cycle; error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r      <= {WD_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == ST_ISSUE) begin
                wd_cnt_r <= {WD_W{1'b0}};
            end else if (state_r == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign timeout_err      = 1'b0;
`endif

    // Next-state decode; a completion in the same cycle as the watchdog expiry wins.
    always_comb begin
        state_s       = state_r;
        done_hit_s    = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (level_r != {LVL_W{1'b0}})) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (cache_done) begin
                    done_hit_s = 1'b1;
                    state_s    = ST_GAP;
`ifdef TRACE_SCHED_TIMEOUT_EN
                end else if (wd_cnt_r == WD_W'(TIMEOUT - 1)) begin
                    timeout_hit_s = 1'b1;
                    state_s       = ST_GAP;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
            2'b01:   level_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
            default: level_s = level_r;
        endcase
    end

    // FIFO storage; flushed logically through the pointers, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[IDX_W-1:0]] <= wr_addr;
        end
    end

    // Control state, pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {LVL_W{1'b0}};
            rd_ptr_r      <= {LVL_W{1'b0}};
            level_r       <= {LVL_W{1'b0}};
            wr_ready_r    <= 1'b1;
            trace_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            issued_r      <= {CNT_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
        end else begin
            state_r       <= state_s;
            level_r       <= level_s;
            wr_ready_r    <= (level_s != LVL_W'(FIFO_DEPTH));
            trace_ready_r <= (state_s == ST_ISSUE);
            busy_r        <= (state_s != ST_IDLE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(LVL_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(LVL_W-1){1'b0}}, 1'b1};
            end
            // Address is loaded on ISSUE entry so it is valid together with the strobe.
            if ((state_r == ST_IDLE) && (state_s == ST_ISSUE)) begin
                mem_addr_r <= fifo_mem_r[rd_ptr_r[IDX_W-1:0]];
            end
            if (done_hit_s && (issued_r != {CNT_W{1'b1}})) begin
                issued_r <= issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
        end
    end

    assign wr_ready     = wr_ready_r;
    assign trace_ready  = trace_ready_r;
    assign busy         = busy_r;
    assign mem_addr     = mem_addr_r;
    assign fifo_level   = level_r;
    assign issued_count = issued_r;
endmodule
